seq_det_1011: RTL and testbench

Serial pattern detector that consumes the one-bit data stream produced by the D latch stage (its `q` output drives `din` here). It is a Moore FSM that recognises the pattern 1011, with overlapping or non-overlapping matching. It also keeps the last four sampled bits as a parallel word and counts matches in a saturating counter with a sticky overflow flag. It sits directly downstream of the latch in the sequential-circuits chain.

---
 rtl/seq_det_1011.sv | 86 ++++++++
 tb/tb_seq_det_1011.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_1011.sv
// rtl/seq_det_1011.sv - Moore 1011 pattern detector with SIPO window and saturating match counter
module seq_det_1011 #(
  parameter int CNT_W   = 8,
  parameter bit OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic             detect,
  output logic [2:0]       state,
  output logic [3:0]       sipo,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_ovf
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    FOUND = 3'd4
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S0;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Illegal encodings recover to S0 even while en is low.
  always_comb begin
    nxt_state = cur_state;
    hit       = 1'b0;
    case (cur_state)
      S0:    if (en) nxt_state = din ? S1 : S0;
      S1:    if (en) nxt_state = din ? S1 : S10;
      S10:   if (en) nxt_state = din ? S101 : S0;
      S101:  if (en) nxt_state = din ? FOUND : S10;
      FOUND: begin
        if (en) begin
          if (din) nxt_state = S1;
          else     nxt_state = OVERLAP ? S10 : S0;
        end
      end
      default: nxt_state = S0;
    endcase
    hit = en && (nxt_state == FOUND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sipo <= 4'b0000;
    end else if (en) begin
      sipo <= {sipo[2:0], din};
    end
  end

  // clr wins over a coincident hit, so that match is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
      cnt_ovf   <= 1'b0;
    end else if (clr) begin
      match_cnt <= '0;
      cnt_ovf   <= 1'b0;
    end else if (hit) begin
      if (match_cnt == {CNT_W{1'b1}}) begin
        cnt_ovf <= 1'b1;
      end else begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

  assign state  = cur_state;
  assign detect = (cur_state == FOUND);

endmodule

// File: tb/tb_seq_det_1011.sv
// tb/tb_seq_det_1011.sv - directed self-checking bench for seq_det_1011
module tb_seq_det_1011;

  logic       clk;
  logic       rst;
  logic       din;
  logic       en;
  logic       clr;

  logic       det_a, det_b, det_c;
  logic [2:0] st_a, st_b, st_c;
  logic [3:0] sipo_a, sipo_b, sipo_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       ovf_a, ovf_b, ovf_c;

  int checks = 0;
  int errors = 0;

  // a: defaults, b: non-overlapping, c: 2-bit counter
  seq_det_1011 #(.CNT_W(8), .OVERLAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
    .detect(det_a), .state(st_a), .sipo(sipo_a), .match_cnt(cnt_a), .cnt_ovf(ovf_a)
  );
  seq_det_1011 #(.CNT_W(8), .OVERLAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
    .detect(det_b), .state(st_b), .sipo(sipo_b), .match_cnt(cnt_b), .cnt_ovf(ovf_b)
  );
  seq_det_1011 #(.CNT_W(2), .OVERLAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
    .detect(det_c), .state(st_c), .sipo(sipo_c), .match_cnt(cnt_c), .cnt_ovf(ovf_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic bit_in(input logic b, input logic e);
    din = b;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    din = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    din = 1'b0;
    clr = 1'b0;
    #2;
    checks++;
    if ({det_a, st_a, sipo_a, cnt_a, ovf_a} !== 17'd0) begin
      errors++;
      $display("FAIL reset_a: got det=%0b st=%0d sipo=%b cnt=%0d ovf=%0b, want all zero",
               det_a, st_a, sipo_a, cnt_a, ovf_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] pat;
    do_reset();
    pat = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      bit_in(pat[i], 1'b1);
      if (i != 0) begin
        checks++;
        if (det_a !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_detect bit%0d: got %0b want 0", 3 - i, det_a);
        end
      end
    end
    checks++;
    if (det_a !== 1'b1 || st_a !== 3'd4) begin
      errors++;
      $display("FAIL basic_detect: got det=%0b st=%0d want det=1 st=4", det_a, st_a);
    end
    checks++;
    if (cnt_a !== 8'd1 || sipo_a !== 4'b1011) begin
      errors++;
      $display("FAIL basic_cnt_sipo: got cnt=%0d sipo=%b want cnt=1 sipo=1011", cnt_a, sipo_a);
    end
    bit_in(1'b0, 1'b1);
    checks++;
    if (det_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width: got det=%0b want 0", det_a);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] stream;
    logic [6:0] got_a, got_b;
    do_reset();
    stream = 7'b1011011;
    got_a  = '0;
    got_b  = '0;
    for (int i = 6; i >= 0; i--) begin
      bit_in(stream[i], 1'b1);
      got_a[i] = det_a;
      got_b[i] = det_b;
    end
    checks++;
    if (got_a !== 7'b0001001 || cnt_a !== 8'd2) begin
      errors++;
      $display("FAIL overlap_on: got det=%b cnt=%0d want det=0001001 cnt=2", got_a, cnt_a);
    end
    checks++;
    if (got_b !== 7'b0001000 || cnt_b !== 8'd1) begin
      errors++;
      $display("FAIL overlap_off: got det=%b cnt=%0d want det=0001000 cnt=1", got_b, cnt_b);
    end
  endtask

  task automatic test_en_gap();
    do_reset();
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bit_in(i[0] ? 1'b0 : 1'b1, 1'b0);
      checks++;
      if (st_a !== 3'd2 || sipo_a !== 4'b0010 || det_a !== 1'b0) begin
        errors++;
        $display("FAIL gap_frozen cyc%0d: got st=%0d sipo=%b det=%0b want st=2 sipo=0010 det=0",
                 i, st_a, sipo_a, det_a);
      end
    end
    bit_in(1'b1, 1'b1);
    checks++;
    if (det_a !== 1'b0 || st_a !== 3'd3) begin
      errors++;
      $display("FAIL gap_s101: got det=%0b st=%0d want det=0 st=3", det_a, st_a);
    end
    bit_in(1'b1, 1'b1);
    checks++;
    if (det_a !== 1'b1 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL gap_detect: got det=%0b cnt=%0d want det=1 cnt=1", det_a, cnt_a);
    end
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    checks++;
    if (det_a !== 1'b1 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL found_hold: got det=%0b cnt=%0d want det=1 cnt=1", det_a, cnt_a);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    logic       exp_ovf [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int m = 0; m < 5; m++) begin
      bit_in(1'b1, 1'b1);
      bit_in(1'b0, 1'b1);
      bit_in(1'b1, 1'b1);
      bit_in(1'b1, 1'b1);
      checks++;
      if (cnt_c !== exp_cnt[m] || ovf_c !== exp_ovf[m] || det_c !== 1'b1) begin
        errors++;
        $display("FAIL sat_match%0d: got cnt=%0d ovf=%0b det=%0b want cnt=%0d ovf=%0b det=1",
                 m + 1, cnt_c, ovf_c, det_c, exp_cnt[m], exp_ovf[m]);
      end
      bit_in(1'b0, 1'b1);
      bit_in(1'b0, 1'b1);
    end
    checks++;
    if (cnt_a !== 8'd5 || ovf_a !== 1'b0 || ovf_c !== 1'b1) begin
      errors++;
      $display("FAIL sat_wide: got cnt_a=%0d ovf_a=%0b ovf_c=%0b want 5 0 1", cnt_a, ovf_a, ovf_c);
    end
  endtask

  task automatic test_clr_on_match();
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    clr = 1'b1;
    bit_in(1'b1, 1'b1);
    clr = 1'b0;
    checks++;
    if (cnt_c !== 2'd0 || ovf_c !== 1'b0 || det_c !== 1'b1) begin
      errors++;
      $display("FAIL clr_match: got cnt=%0d ovf=%0b det=%0b want cnt=0 ovf=0 det=1",
               cnt_c, ovf_c, det_c);
    end
    checks++;
    if (cnt_a !== 8'd0 || sipo_a !== 4'b1011) begin
      errors++;
      $display("FAIL clr_wide: got cnt=%0d sipo=%b want cnt=0 sipo=1011", cnt_a, sipo_a);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] tail;
    do_reset();
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    checks++;
    if (st_a !== 3'd3 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL pre_rst: got st=%0d cnt=%0d want st=3 cnt=1", st_a, cnt_a);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({det_a, st_a, sipo_a, cnt_a, ovf_a} !== 17'd0 || cnt_c !== 2'd0) begin
      errors++;
      $display("FAIL async_rst: got det=%0b st=%0d sipo=%b cnt=%0d ovf=%0b cnt_c=%0d want all zero",
               det_a, st_a, sipo_a, cnt_a, ovf_a, cnt_c);
    end
    #1;
    rst = 1'b0;
    tail = 5'b11011;
    for (int i = 4; i >= 0; i--) begin
      bit_in(tail[i], 1'b1);
      if (i != 0) begin
        checks++;
        if (det_a !== 1'b0) begin
          errors++;
          $display("FAIL post_rst_early bit%0d: got det=%0b want 0", 4 - i, det_a);
        end
      end
    end
    checks++;
    if (det_a !== 1'b1 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL post_rst_detect: got det=%0b cnt=%0d want det=1 cnt=1", det_a, cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_en_gap();
    test_saturation();
    test_clr_on_match();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
